mem_addr_gen: RTL and testbench

Parametrised data-memory address generator between the ALU and the data RAM. It selects among three sources: the ALU word address, a manually chosen display line, and an auto-scanning line counter that walks the line window for the board display. It also flags misaligned and out-of-range ALU accesses. All outputs are registered, so the RAM sees a stable, glitch-free address one cycle after selection.

---
 rtl/mem_addr_gen.sv | 97 +++++++++
 tb/tb_mem_addr_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: registered RAM word-address mux between the ALU, a manual display
// line and an auto-scanning line counter, with ALU misalign/out-of-range flags.
module mem_addr_gen #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int LINE_W    = 4,
    parameter int LINE_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mode,
    input  logic [LINE_W-1:0] line_num,
    input  logic [DATA_W-1:0] in_alu,
    input  logic              mem_req,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              misalign,
    output logic              oob,
    output logic [LINE_W-1:0] scan_line,
    output logic              scan_wrap
);
    localparam logic [2:0]        ModeLine  = 3'b100;
    localparam logic [2:0]        ModeScan  = 3'b101;
    localparam logic [ADDR_W-1:0] LineBaseW = ADDR_W'(LINE_BASE);

    typedef enum logic {Idle, Scan} state_e;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic              oob_q, oob_d;
    logic              aluSel;

    // Entry edge always clears the counter, so a step arriving with it is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (mode != ModeScan) begin
            state_d = Idle;
        end else if (state_q == Idle) begin
            state_d = Scan;
            cnt_d   = '0;
        end else if (step) begin
            cnt_d  = cnt_q + LINE_W'(1);
            wrap_d = (cnt_q == '1);
        end
    end

    always_comb begin
        aluSel  = 1'b0;
        addr_d  = in_alu[ADDR_W+1:2];
        valid_d = mem_req;
        if (mode == ModeLine) begin
            addr_d  = LineBaseW + ADDR_W'(line_num);
            valid_d = 1'b1;
        end else if (mode == ModeScan) begin
            addr_d  = LineBaseW + ADDR_W'(cnt_d);
            valid_d = 1'b1;
        end else begin
            aluSel = 1'b1;
        end
        misalign_d = aluSel && mem_req && (in_alu[1:0] != 2'b00);
        oob_d      = aluSel && mem_req && (in_alu[DATA_W-1:ADDR_W+2] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= Idle;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            oob_q      <= oob_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign misalign   = misalign_q;
    assign oob        = oob_q;
    assign scan_line  = cnt_q;
    assign scan_wrap  = wrap_q;
endmodule

// File: tb/tb_mem_addr_gen.sv
// tb_mem_addr_gen: directed and randomized checks of mem_addr_gen against a
// behavioural model, with two instances covering LINE_BASE = 0 and 16.
module tb_mem_addr_gen;
    localparam int LINES = 16;
    localparam int ADDRS = 1024;
    localparam int BASE1 = 16;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mode;
    logic [3:0]  line_num;
    logic [31:0] in_alu;
    logic        mem_req;
    logic        step;

    logic [9:0]  addr0, addr1;
    logic        valid0, valid1, mis0, mis1, oob0, oob1, wrap0, wrap1;
    logic [3:0]  line0, line1;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    int mAddr0 = 0, mAddr1 = 0, mCount = 0;
    bit mValid = 0, mMis = 0, mOob = 0, mWrap = 0, mScanning = 0;

    mem_addr_gen #(.DATA_W(32), .ADDR_W(10), .LINE_W(4), .LINE_BASE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .line_num(line_num), .in_alu(in_alu),
        .mem_req(mem_req), .step(step), .addr(addr0), .addr_valid(valid0),
        .misalign(mis0), .oob(oob0), .scan_line(line0), .scan_wrap(wrap0)
    );

    mem_addr_gen #(.DATA_W(32), .ADDR_W(10), .LINE_W(4), .LINE_BASE(BASE1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .line_num(line_num), .in_alu(in_alu),
        .mem_req(mem_req), .step(step), .addr(addr1), .addr_valid(valid1),
        .misalign(mis1), .oob(oob1), .scan_line(line1), .scan_wrap(wrap1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] m, input logic [3:0] ln, input logic [31:0] a,
                                 input logic r, input logic s);
        @(negedge clk);
        mode     = m;
        line_num = ln;
        in_alu   = a;
        mem_req  = r;
        step     = s;
    endtask

    // Reference model: outputs derived from source-selection rules in plain integer arithmetic.
    always @(posedge clk or negedge rst_n) begin
        bit isAlu;
        int sel;
        if (!rst_n) begin
            mScanning = 0; mCount = 0; mWrap = 0;
            mAddr0 = 0; mAddr1 = 0; mValid = 0; mMis = 0; mOob = 0;
        end else begin
            isAlu = (mode != 3'b100) && (mode != 3'b101);
            if (mode == 3'b101) begin
                if (!mScanning) begin
                    mScanning = 1; mCount = 0; mWrap = 0;
                end else if (step) begin
                    mCount = (mCount + 1) % LINES;
                    mWrap  = (mCount == 0);
                end else begin
                    mWrap = 0;
                end
            end else begin
                mScanning = 0; mWrap = 0;
            end
            sel = (mode == 3'b100) ? int'(line_num) : mCount;
            if (isAlu) begin
                mAddr0 = int'((in_alu / 4) % ADDRS);
                mAddr1 = mAddr0;
            end else begin
                mAddr0 = sel % ADDRS;
                mAddr1 = (BASE1 + sel) % ADDRS;
            end
            mValid = isAlu ? mem_req : 1'b1;
            mMis   = isAlu && mem_req && (in_alu % 4 != 0);
            mOob   = isAlu && mem_req && (in_alu >= 32'(ADDRS * 4));
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp addr0", 32'(addr0), 32'(mAddr0));
            checkOutput("cmp addr1", 32'(addr1), 32'(mAddr1));
            checkOutput("cmp valid0", 32'(valid0), 32'(mValid));
            checkOutput("cmp valid1", 32'(valid1), 32'(mValid));
            checkOutput("cmp misalign", 32'(mis0), 32'(mMis));
            checkOutput("cmp oob", 32'(oob0), 32'(mOob));
            checkOutput("cmp scan_line0", 32'(line0), 32'(mCount));
            checkOutput("cmp scan_line1", 32'(line1), 32'(mCount));
            checkOutput("cmp scan_wrap0", 32'(wrap0), 32'(mWrap));
            checkOutput("cmp scan_wrap1", 32'(wrap1), 32'(mWrap));
        end
    end

    initial begin
        rst_n = 1'b0; mode = 3'd0; line_num = 4'd0; in_alu = 32'h0000_0FFC; mem_req = 1'b1; step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset addr", 32'(addr0), 32'h0);
        checkOutput("reset valid", 32'(valid0), 32'h0);
        checkOutput("reset scan_line", 32'(line0), 32'h0);
        checkEn = 1;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("release addr", 32'(addr0), 32'h3FF);
        checkOutput("release valid", 32'(valid0), 32'h1);
        checkOutput("release misalign", 32'(mis0), 32'h0);
        checkOutput("release oob", 32'(oob0), 32'h0);

        applyStimulus(3'd0, 4'd0, 32'h0000_0046, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("alu addr", 32'(addr0), 32'h011);
        checkOutput("alu misalign", 32'(mis0), 32'h1);
        checkOutput("alu oob", 32'(oob0), 32'h0);
        applyStimulus(3'd0, 4'd0, 32'h0000_1004, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput("oob addr", 32'(addr0), 32'h001);
        checkOutput("oob flag", 32'(oob0), 32'h1);
        checkOutput("oob misalign", 32'(mis0), 32'h0);
        applyStimulus(3'd0, 4'd0, 32'h0000_1007, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("noreq valid", 32'(valid0), 32'h0);
        checkOutput("noreq misalign", 32'(mis0), 32'h0);
        checkOutput("noreq oob", 32'(oob0), 32'h0);

        applyStimulus(3'b100, 4'd7, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("line addr base0", 32'(addr0), 32'd7);
        checkOutput("line addr base16", 32'(addr1), 32'd23);
        checkOutput("line valid", 32'(valid0), 32'h1);

        applyStimulus(3'b101, 4'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("scan entry line", 32'(line0), 32'd0);
        checkOutput("scan entry addr1", 32'(addr1), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(3'b101, 4'd0, 32'h0, 1'b0, 1'b1);
            @(posedge clk); #1;
            checkOutput("scan step line", 32'(line0), 32'(i % 16));
            checkOutput("scan step addr0", 32'(addr0), 32'(i % 16));
            checkOutput("scan step addr1", 32'(addr1), 32'(16 + i % 16));
            checkOutput("scan step wrap", 32'(wrap0), (i == 16) ? 32'h1 : 32'h0);
        end
        for (int i = 1; i <= 5; i++) applyStimulus(3'b101, 4'd0, 32'h0, 1'b0, 1'b1);
        applyStimulus(3'd0, 4'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("exit with step line", 32'(line0), 32'd5);
        applyStimulus(3'd0, 4'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("idle hold line", 32'(line0), 32'd5);
        applyStimulus(3'b101, 4'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("reentry line", 32'(line0), 32'd0);

        for (int i = 1; i <= 9; i++) applyStimulus(3'b101, 4'd0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("pre-reset line", 32'(line0), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset line", 32'(line0), 32'd0);
        checkOutput("async reset addr", 32'(addr0), 32'd0);
        @(posedge clk); #1;
        checkOutput("held reset line", 32'(line0), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset entry line", 32'(line0), 32'd0);
        checkOutput("post-reset entry addr1", 32'(addr1), 32'd16);
        @(posedge clk); #1;
        checkOutput("post-reset step line", 32'(line0), 32'd1);

        for (int n = 0; n < 600; n++) begin
            logic [2:0]  m;
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1, 2: m = 3'b101;
                3, 4:    m = 3'b100;
                default: m = 3'($urandom_range(0, 7));
            endcase
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8191)) : $urandom;
            applyStimulus(m, 4'($urandom_range(0, 15)), a, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk); #3 rst_n = 1'b0;
                @(posedge clk); #3 rst_n = 1'b1;
            end
        end

        @(posedge clk); #1;
        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
